div_stall_unit: RTL
===================

Name: div_stall_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the Execute stage.
- Drives the stall_div request consumed by the pipeline hazard logic.
- Holds the pipeline while dividing, then presents a stable HI/LO result for exactly the cycle(s) the instruction leaves Execute.
- Honors exception flushes by aborting in-flight divisions.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  DIV/DIVU instruction present and valid in Execute.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- opa  input  WIDTH  dividend (rs value after forwarding).
- opb  input  WIDTH  divisor (rt value after forwarding).
- hold  input  1  pipeline frozen by instruction/data memory stall.
- annul  input  1  exception flush of Execute (nonzero excepttype).
- stall_div  output  1  request to freeze F/D/E.
- result_valid  output  1  hi_o/lo_o are final for the current start.
- hi_o  output  WIDTH  remainder.
- lo_o  output  WIDTH  quotient.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State IDLE; counter 0; hi_o, lo_o = 0.
  - stall_div = 0, result_valid = 0.
  - Reset mid-division discards all work.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_div = start & ~annul, combinational, so the hazard logic sees it in the same cycle.
  - On start & ~annul with opb != 0:
    - Latch |opa|, |opb| (absolute values when signed_div, raw otherwise).
    - Latch quotient sign = opa[31]^opb[31] and remainder sign = opa[31] (signed only).
    - Counter = 0; go to BUSY.
  - On start & ~annul with opb == 0: go to DONE next cycle with lo_o = all ones, hi_o = opa (raw).
- BUSY:
  - stall_div = 1.
  - One quotient bit per cycle: shift the {rem, quo} pair left by 1, then trial-subtract the divisor from rem. If non-negative, keep the difference and set quo[0] = 1.
  - Counter increments each cycle. When counter == WIDTH-1 on a clock edge:
    - Apply the sign corrections (two's-complement negate quotient/remainder as latched).
    - Load hi_o/lo_o and go to DONE.
  - Total stall_div high = 1 accept cycle + WIDTH busy cycles = 33 cycles for WIDTH=32.
- DONE:
  - result_valid = 1, stall_div = 0; hi_o/lo_o held stable.
  - If hold = 1: stay in DONE, keep outputs. start remains high in this state and is ignored (no restart).
  - If hold = 0: go to IDLE next edge. hi_o/lo_o keep their last value until the next completion.
- annul (any state):
  - Forces stall_div = 0 in the same cycle.
  - Next state is IDLE; result_valid = 0 next cycle; hi_o/lo_o not updated.
  - annul has priority over start and hold.
- Back-to-back divisions: the second start is accepted in IDLE the cycle after DONE exits. No overlap, no lost start.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo_o = 0x80000000, hi_o = 0, via the normal unsigned path plus sign fix.
- start deasserted while BUSY (should not occur absent annul): completes normally, then DONE → IDLE.
- All arithmetic is unsigned WIDTH+1 bits internally; no X propagation from unused operand bits.

Test Plan:
- Unsigned: start=1, signed_div=0, opa=100, opb=7 → stall_div high 33 cycles, then result_valid=1, lo_o=14, hi_o=2, stall_div=0.
- Signed: opa=0xFFFFFFF9 (-7), opb=2 → lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1); opa=7, opb=0xFFFFFFFE → lo_o=0xFFFFFFFD, hi_o=1.
- Overflow and zero divisor:
  - signed 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
  - opb=0, opa=0x1234 → stall_div high 1 cycle, result_valid next cycle, lo_o=0xFFFFFFFF, hi_o=0x1234.
- Hold in DONE: 100/7 completes with hold=1 for 5 cycles → result_valid stays 1, outputs stable, stall_div=0, no restart. Release hold → IDLE next cycle.
- annul at BUSY cycle 10 → stall_div=0 the same cycle, IDLE next cycle, hi_o/lo_o unchanged from the prior result. A fresh start of 9/3 then yields lo_o=3, hi_o=0.
- resetn pulsed low mid-BUSY → all outputs 0 immediately (asynchronous). After release, a new start of 100/7 gives the correct 14/2.

Source files
------------

// File: rtl/div_stall_unit.sv
`timescale 1ns/1ps
// div_stall_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in the
// Execute stage. It raises stall_div while a quotient is being formed, then
// presents a stable HI (remainder) / LO (quotient) pair while result_valid is
// high. An exception flush (annul) aborts any division in flight.
module div_stall_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hold,
  input  logic             annul,
  output logic             stall_div,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             negQuo;
  logic             negRem;

  logic             accept;
  logic             zeroDivisor;
  logic             lastStep;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trialDiff;
  logic             trialOk;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;

  assign hi_o = hiReg;
  assign lo_o = loReg;

  // Operand magnitudes and one restoring step. The partial remainder is always
  // below the divisor, so a borrow out of the WIDTH+1 bit subtraction lands in
  // the top bit exactly when the trial subtraction went negative.
  always_comb begin
    zeroDivisor = (opb == '0);
    absA        = (signed_div && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
    absB        = (signed_div && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;
    lastStep    = (count == CNT_W'(WIDTH - 1));
    remShift    = {remReg, quoReg[WIDTH-1]};
    trialDiff   = remShift - {1'b0, divisor};
    trialOk     = ~trialDiff[WIDTH];
    nextRem     = trialOk ? trialDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
    nextQuo     = {quoReg[WIDTH-2:0], trialOk};
  end

  // State register; reset discards any division in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs; annul overrides start and hold everywhere.
  always_comb begin
    nextState    = state;
    stall_div    = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          stall_div = 1'b1;
          accept    = 1'b1;
          nextState = zeroDivisor ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (annul) begin
          nextState = IDLE;
        end else begin
          stall_div = 1'b1;
          if (lastStep) begin
            nextState = DONE;
          end
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (annul || !hold) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate while busy, and load HI/LO only
  // on a normal completion or a divide-by-zero so annul leaves them untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      divisor <= '0;
      remReg  <= '0;
      quoReg  <= '0;
      negQuo  <= 1'b0;
      negRem  <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
    end else if (accept) begin
      count <= '0;
      if (zeroDivisor) begin
        hiReg <= opa;
        loReg <= '1;
      end else begin
        divisor <= absB;
        remReg  <= '0;
        quoReg  <= absA;
        negQuo  <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        negRem  <= signed_div & opa[WIDTH-1];
      end
    end else if (state == BUSY && !annul) begin
      remReg <= nextRem;
      quoReg <= nextQuo;
      count  <= count + CNT_W'(1);
      if (lastStep) begin
        hiReg <= negRem ? (~nextRem + 1'b1) : nextRem;
        loReg <= negQuo ? (~nextQuo + 1'b1) : nextQuo;
      end
    end
  end

endmodule
